// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment receive path: segment codes
// in {a,b,c,d,e,f,g} order (a = bit 6) and the acceptance FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b0000000;

  localparam logic [6:0] SEGCODE_0  = 7'b1111110;
  localparam logic [6:0] SEGCODE_1  = 7'b0110000;
  localparam logic [6:0] SEGCODE_2  = 7'b1101101;
  localparam logic [6:0] SEGCODE_3  = 7'b1111001;
  localparam logic [6:0] SEGCODE_4  = 7'b0110011;
  localparam logic [6:0] SEGCODE_5  = 7'b1011011;
  localparam logic [6:0] SEGCODE_6  = 7'b1011111;
  localparam logic [6:0] SEGCODE_7  = 7'b1110000;
  localparam logic [6:0] SEGCODE_8  = 7'b1111111;
  localparam logic [6:0] SEGCODE_9  = 7'b1111011;
  localparam logic [6:0] SEGCODE_A  = 7'b1110111;
  localparam logic [6:0] SEGCODE_B  = 7'b0011111;
  localparam logic [6:0] SEGCODE_C  = 7'b1001110;
  localparam logic [6:0] SEGCODE_D  = 7'b0111101;
  localparam logic [6:0] SEGCODE_E  = 7'b1001111;
  localparam logic [6:0] SEGCODE_F  = 7'b1000111;

  // S_TRACK: pattern still settling; S_LOCKED: pattern accepted and held.
  typedef enum logic {
    S_TRACK  = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_lut.sv
// Combinational segment-pattern to hex lookup. hit=0 for blank and for
// any pattern outside the 16-entry table; nibble is 0 whenever hit=0.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  // Table match; anything unlisted falls through to a miss.
  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEGCODE_0: nibble = 4'h0;
      SEGCODE_1: nibble = 4'h1;
      SEGCODE_2: nibble = 4'h2;
      SEGCODE_3: nibble = 4'h3;
      SEGCODE_4: nibble = 4'h4;
      SEGCODE_5: nibble = 4'h5;
      SEGCODE_6: nibble = 4'h6;
      SEGCODE_7: nibble = 4'h7;
      SEGCODE_8: nibble = 4'h8;
      SEGCODE_9: nibble = 4'h9;
      SEGCODE_A: nibble = 4'hA;
      SEGCODE_B: nibble = 4'hB;
      SEGCODE_C: nibble = 4'hC;
      SEGCODE_D: nibble = 4'hD;
      SEGCODE_E: nibble = 4'hE;
      SEGCODE_F: nibble = 4'hF;
      default: begin
        hit    = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_to_hex_rx.sv
// Seven-segment receiver: registers the raw segment bus, requires a pattern
// to be stable for STABLE_CYCLES samples, decodes it and presents the digit
// on a valid/ready output with a sticky overrun flag.
module seg7_to_hex_rx
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       out_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Stability counter step, holding at CNT_MAX once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) return c;
    return c + CNT_W'(1);
  endfunction

  logic [6:0]       seg_q;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  // Last pattern accepted (blank included); a re-acceptance of the same
  // pattern after a short glitch must not emit a second digit.
  logic [6:0]       last_q;

  logic             chg;
  logic             accept;
  logic             emit;
  logic             slot_free;
  logic             lut_hit;
  logic [3:0]       lut_nibble;

  // ---- stage 0: input sample and stability tracking ----

  // seg_in is compared with the value already in seg_q, so "chg" means
  // the sample landing on this edge differs from the previous one.
  assign chg = (seg_in != seg_q);

  // Sample the bus every cycle and count how long it has been unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      cnt   <= '0;
    end else begin
      seg_q <= seg_in;
      if (chg) cnt <= '0;
      else     cnt <= sat_inc(cnt);
    end
  end

  // ---- stage 1: acceptance, decode and output register ----

  seg7_lut u_lut (
    .seg    (seg_q),
    .hit    (lut_hit),
    .nibble (lut_nibble)
  );

  assign accept    = (state == S_TRACK) && !chg && (cnt == CNT_MAX);
  assign emit      = accept && (seg_q != SEG_BLANK) && (seg_q != last_q);
  assign slot_free = !out_valid || out_ready;

  // Acceptance FSM with registered digit output and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_TRACK;
      last_q     <= SEG_BLANK;
      out_valid  <= 1'b0;
      out_nibble <= 4'h0;
      out_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        S_TRACK:  if (accept) state <= S_LOCKED;
        S_LOCKED: if (chg)    state <= S_TRACK;
        default:  state <= S_TRACK;
      endcase

      if (accept) last_q <= seg_q;

      // Drain first; a same-edge emission below overrides the clear.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (emit) begin
        if (slot_free) begin
          out_valid  <= 1'b1;
          out_nibble <= lut_hit ? lut_nibble : 4'h0;
          out_err    <= !lut_hit;
        end else begin
          overrun    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_hex_rx.sv
// Scoreboard bench for seg7_to_hex_rx: stimulus pushes expected digits,
// a monitor pops and compares on every out_valid & out_ready transfer.
module tb_seg7_to_hex_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_nibble;
  logic       out_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  int n_push = 0;

  logic [4:0] exp_q[$];

  logic [6:0] codes [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg7_to_hex_rx #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_nibble (out_nibble),
    .out_err    (out_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic err, input logic [3:0] nib);
    exp_q.push_back({err, nib});
    n_push++;
  endtask

  // Monitor: every accepted transfer must match the head of the queue.
  initial begin
    logic [4:0] got;
    logic [4:0] want;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_xfer++;
        got = {out_err, out_nibble};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digit actual=%0h required=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL digit actual=%0h required=%0h", got, want);
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    seg_in    = 7'b0000000;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid",   32'(out_valid),  32'd0);
    chk("rst_nibble",  32'(out_nibble), 32'd0);
    chk("rst_err",     32'(out_err),    32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
    rst = 1'b0;
    repeat (8) tick();

    // Clean decode of all 16 codes, blank between, latency 4 from seg_q.
    for (int i = 0; i < 16; i++) begin
      push_exp(1'b0, 4'(i));
      seg_in = codes[i];
      repeat (4) tick();
      chk("lat_pre",  32'(out_valid), 32'd0);
      tick();
      chk("lat_rise", 32'(out_valid), 32'd1);
      repeat (3) tick();
      seg_in = 7'b0000000;
      repeat (8) tick();
    end
    chk("clean_count", 32'(n_xfer), 32'd16);

    // Short glitch to 8 and back to 1: only one emission of 1.
    push_exp(1'b0, 4'h1);
    seg_in = 7'b0110000;
    repeat (10) tick();
    seg_in = 7'b1111111;
    repeat (2) tick();
    seg_in = 7'b0110000;
    repeat (10) tick();
    chk("glitch_count", 32'(n_xfer), 32'd17);
    seg_in = 7'b0000000;
    repeat (8) tick();

    // Repeat re-arm through blank, then a 1-cycle dropout does not re-emit.
    push_exp(1'b0, 4'h2);
    seg_in = 7'b1101101;
    repeat (8) tick();
    seg_in = 7'b0000000;
    repeat (8) tick();
    push_exp(1'b0, 4'h2);
    seg_in = 7'b1101101;
    repeat (8) tick();
    seg_in = 7'b0000000;
    tick();
    seg_in = 7'b1101101;
    repeat (8) tick();
    chk("repeat_count", 32'(n_xfer), 32'd19);
    seg_in = 7'b0000000;
    repeat (8) tick();

    // Simultaneous drain of 5 and acceptance of 4 on the same edge.
    out_ready = 1'b0;
    push_exp(1'b0, 4'h5);
    seg_in = 7'b1011011;
    repeat (6) tick();
    chk("hold5_valid",  32'(out_valid),  32'd1);
    chk("hold5_nibble", 32'(out_nibble), 32'd5);
    push_exp(1'b0, 4'h4);
    seg_in = 7'b0110011;
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    chk("simul_valid",   32'(out_valid),  32'd1);
    chk("simul_nibble",  32'(out_nibble), 32'd4);
    chk("simul_overrun", 32'(overrun),    32'd0);
    tick();
    out_ready = 1'b0;
    chk("simul_drained", 32'(out_valid), 32'd0);
    seg_in = 7'b0000000;
    repeat (8) tick();

    // Error pattern under backpressure, then a dropped 3 sets overrun.
    push_exp(1'b1, 4'h0);
    seg_in = 7'b1010101;
    repeat (6) tick();
    chk("err_valid",   32'(out_valid),  32'd1);
    chk("err_flag",    32'(out_err),    32'd1);
    chk("err_nibble",  32'(out_nibble), 32'd0);
    chk("err_overrun", 32'(overrun),    32'd0);
    seg_in = 7'b1111001;
    repeat (6) tick();
    chk("bp_valid",   32'(out_valid),  32'd1);
    chk("bp_err",     32'(out_err),    32'd1);
    chk("bp_nibble",  32'(out_nibble), 32'd0);
    chk("bp_overrun", 32'(overrun),    32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_sticky",  32'(overrun),   32'd1);

    // Reset mid-count with a digit pending; the held pattern re-emits.
    seg_in = 7'b0000000;
    repeat (8) tick();
    seg_in = 7'b1110000;
    repeat (6) tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    seg_in = 7'b1111111;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid",   32'(out_valid),  32'd0);
    chk("mid_rst_nibble",  32'(out_nibble), 32'd0);
    chk("mid_rst_err",     32'(out_err),    32'd0);
    chk("mid_rst_overrun", 32'(overrun),    32'd0);
    rst = 1'b0;
    push_exp(1'b0, 4'h8);
    repeat (4) tick();
    chk("post_rst_pre",  32'(out_valid), 32'd0);
    tick();
    chk("post_rst_rise", 32'(out_valid),  32'd1);
    chk("post_rst_nib",  32'(out_nibble), 32'd8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_drained", 32'(out_valid), 32'd0);
    repeat (4) tick();

    chk("total_xfers", 32'(n_xfer), 32'(n_push));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
